// File: rtl/usb_in_arbiter.sv
// usb_in_arbiter: packet-aware round-robin arbiter sharing one CDC IN byte channel between two sources; define ARB_TIMEOUT_EN to release a grant whose source stalls mid-burst
module usb_in_arbiter #(
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] src0_data_i,
  input  logic       src0_valid_i,
  input  logic       src0_last_i,
  output logic       src0_ready_o,
  input  logic [7:0] src1_data_i,
  input  logic       src1_valid_i,
  input  logic       src1_last_i,
  output logic       src1_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic [1:0] grant_o
);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] burst_cnt;
  logic          rr;
  logic          out_free, acc0, acc1, acc, acc_last, burst_end, release_g, timed_out;
  logic [7:0]    acc_data;
  assign grant_o      = {state == GRANT1, state == GRANT0};
  assign out_free     = ~in_valid_o | in_ready_i;
  assign src0_ready_o = grant_o[0] & out_free;
  assign src1_ready_o = grant_o[1] & out_free;
  assign acc0         = src0_valid_i & src0_ready_o;
  assign acc1         = src1_valid_i & src1_ready_o;
  assign acc          = acc0 | acc1;
  assign acc_data     = acc0 ? src0_data_i : src1_data_i;
  assign acc_last     = acc0 ? src0_last_i : src1_last_i;
  assign burst_end    = acc & (acc_last | (burst_cnt + CW'(1) == CW'(MAX_BURST)));
  assign release_g    = burst_end | timed_out;
`ifdef ARB_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;
  logic          stalled;
  assign stalled   = (state != IDLE) & ~(grant_o[0] ? src0_valid_i : src1_valid_i);
  assign timed_out = stalled & (idle_cnt == IW'(TIMEOUT - 1));
  // count granted cycles without a request; any accept or release restarts it
  always_ff @(posedge clk_i)
    if (!reset_n_i || acc || release_g) idle_cnt <= '0;
    else if (stalled) idle_cnt <= idle_cnt + IW'(1);
`else
  logic unused_timeout;
  assign timed_out      = 1'b0;
  assign unused_timeout = TIMEOUT != 0;
`endif
  // arbitration: tie goes to the source that did not hold the last grant
  always_comb begin
    state_nx = state == IDLE ? ((src0_valid_i & (~src1_valid_i | rr)) ? GRANT0 : src1_valid_i ? GRANT1 : IDLE)
             : release_g ? IDLE : state;
  end
  // state, round-robin pointer and per-grant burst counter
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      state     <= IDLE;
      rr        <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state <= state_nx;
      if (release_g) begin
        rr        <= grant_o[1];
        burst_cnt <= '0;
      end else if (acc) burst_cnt <= burst_cnt + CW'(1);
    end
  // registered output stage: load on accept, drop valid once drained
  always_ff @(posedge clk_i)
    if (!reset_n_i) begin
      in_valid_o <= 1'b0;
      in_data_o  <= 8'h00;
    end else if (acc) begin
      in_valid_o <= 1'b1;
      in_data_o  <= acc_data;
    end else if (in_ready_i) in_valid_o <= 1'b0;
endmodule

// File: tb/tb_usb_in_arbiter.sv
// tb_usb_in_arbiter: scenario and randomized checks of usb_in_arbiter against a burst-level reference model
module tb_usb_in_arbiter;
  localparam int MB = 4;
  localparam int TO = 8;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] s0_data, s1_data, in_data;
  logic       s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic       in_valid, in_ready;
  logic [1:0] grant;
  int         tests = 0, fails = 0, stalls;
  logic [7:0] q0_d[$], q1_d[$], out_q[$], exp_q[$];
  bit         q0_l[$], q1_l[$], rdy_pat[$];
  logic [1:0] g_tr[$];

  always #5 clk = ~clk;

  usb_in_arbiter #(.MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .src0_data_i(s0_data), .src0_valid_i(s0_valid), .src0_last_i(s0_last), .src0_ready_o(s0_ready),
    .src1_data_i(s1_data), .src1_valid_i(s1_valid), .src1_last_i(s1_last), .src1_ready_o(s1_ready),
    .in_data_o(in_data), .in_valid_o(in_valid), .in_ready_i(in_ready), .grant_o(grant)
  );

  task automatic do_reset();
    reset_n = 1'b0;
    s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
    s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
    in_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
  endtask

  // burst-level model: whole bursts alternate, each ends at last, MAX_BURST bytes or an exhausted source
  task automatic model_order();
    int i0 = 0, i1 = 0, src, n;
    bit rr = 1'b1, h0, h1, lst;
    exp_q.delete();
    while (i0 < q0_d.size() || i1 < q1_d.size()) begin
      h0 = i0 < q0_d.size();
      h1 = i1 < q1_d.size();
      src = (h0 && h1) ? int'(!rr) : (h0 ? 0 : 1);
      n = 0;
      forever begin
        if (src == 0) begin exp_q.push_back(q0_d[i0]); lst = q0_l[i0]; i0++; end
        else begin exp_q.push_back(q1_d[i1]); lst = q1_l[i1]; i1++; end
        n++;
        if (lst || n == MB || (src == 0 ? i0 == q0_d.size() : i1 == q1_d.size())) break;
      end
      rr = src[0];
    end
  endtask

  // stream both queues through the DUT; mode 0: always ready, 1: random, 2: rdy_pat
  task automatic run_streams(input int mode, input int budget);
    int i0 = 0, i1 = 0, cyc = 0;
    bit a0, a1, pv = 1'b0;
    logic [7:0] pd = 8'h00;
    out_q.delete(); g_tr.delete(); stalls = 0;
    forever begin
      s0_valid = i0 < q0_d.size(); s0_data = 8'h00; s0_last = 1'b0;
      s1_valid = i1 < q1_d.size(); s1_data = 8'h00; s1_last = 1'b0;
      if (s0_valid) begin s0_data = q0_d[i0]; s0_last = q0_l[i0]; end
      if (s1_valid) begin s1_data = q1_d[i1]; s1_last = q1_l[i1]; end
      in_ready = 1'b1;
      if (mode == 1) in_ready = $urandom_range(0, 3) != 0;
      if (mode == 2 && cyc < rdy_pat.size()) in_ready = rdy_pat[cyc];
      @(negedge clk);
      g_tr.push_back(grant);
      if (pv) begin
        tests++;
        if (in_valid !== 1'b1 || in_data !== pd) begin
          fails++; $display("FAIL stall_hold: valid=%b data=%h, required 1/%h", in_valid, in_data, pd);
        end
      end
      pv = in_valid & ~in_ready; pd = in_data;
      if (pv) begin
        stalls++; tests++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
          fails++; $display("FAIL stall_ready: ready0=%b ready1=%b, required 0/0", s0_ready, s1_ready);
        end
      end
      if (in_valid && in_ready) out_q.push_back(in_data);
      a0 = s0_valid & s0_ready;
      a1 = s1_valid & s1_ready;
      @(posedge clk); #1;
      i0 += int'(a0); i1 += int'(a1); cyc++;
      if (i0 == q0_d.size() && i1 == q1_d.size() && !in_valid) break;
      if (cyc >= budget) begin
        tests++; fails++; $display("FAIL run_timeout: sent %0d/%0d and %0d/%0d after %0d cycles", i0, q0_d.size(), i1, q1_d.size(), cyc);
        break;
      end
    end
    s0_valid = 1'b0; s0_last = 1'b0; s1_valid = 1'b0; s1_last = 1'b0; in_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++;
    if (grant !== 2'b00 || in_valid !== 1'b0 || in_data !== 8'h00) begin
      fails++; $display("FAIL reset_state: grant=%b valid=%b data=%h, required 00/0/00", grant, in_valid, in_data);
    end
    tests++;
    if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: ready0=%b ready1=%b, required 0/0", s0_ready, s1_ready);
    end
  endtask

  task automatic test_single_packet();
    logic [7:0] b [3] = '{8'hA1, 8'hA2, 8'hA3};
    do_reset();
    s0_valid = 1'b1; s0_data = b[0]; s0_last = 1'b0;
    @(negedge clk);
    tests++;
    if (grant !== 2'b00) begin fails++; $display("FAIL sp_arb: grant=%b, required 00", grant); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (grant !== 2'b01 || s0_ready !== 1'b1) begin
        fails++; $display("FAIL sp_grant[%0d]: grant=%b ready0=%b, required 01/1", i, grant, s0_ready);
      end
      @(posedge clk); #1;
      tests++;
      if (in_valid !== 1'b1 || in_data !== b[i]) begin
        fails++; $display("FAIL sp_data[%0d]: valid=%b data=%h, required 1/%h", i, in_valid, in_data, b[i]);
      end
      if (i < 2) begin s0_data = b[i+1]; s0_last = i == 1; end
      else begin s0_valid = 1'b0; s0_last = 1'b0; end
    end
    @(negedge clk);
    tests++;
    if (grant !== 2'b00) begin fails++; $display("FAIL sp_release: grant=%b, required 00", grant); end
    @(posedge clk); #1;
    tests++;
    if (in_valid !== 1'b0) begin fails++; $display("FAIL sp_drain: valid=%b, required 0", in_valid); end
  endtask

  task automatic test_tie();
    logic [1:0] eg [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    do_reset();
    q0_d = '{8'h10, 8'h11}; q0_l = '{1'b0, 1'b1};
    q1_d = '{8'h20, 8'h21}; q1_l = '{1'b0, 1'b1};
    run_streams(0, 50);
    model_order();
    tests++;
    if (out_q.size() != exp_q.size()) begin fails++; $display("FAIL tie_count: %0d bytes, required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin fails++; $display("FAIL tie_byte[%0d]: required %h", i, exp_q[i]); end
    end
    foreach (eg[i]) begin
      tests++;
      if (i >= g_tr.size() || g_tr[i] !== eg[i]) begin fails++; $display("FAIL tie_grant[%0d]: required %b", i, eg[i]); end
    end
    q0_d = '{8'h30}; q0_l = '{1'b1};
    q1_d = '{8'h40}; q1_l = '{1'b1};
    run_streams(0, 50);
    tests++;
    if (out_q.size() != 2 || out_q[0] !== 8'h30 || out_q[1] !== 8'h40) begin
      fails++; $display("FAIL tie_next: %0d bytes first=%h, required 2 bytes first=30", out_q.size(), out_q.size() > 0 ? out_q[0] : 8'h00);
    end
  endtask

  task automatic test_max_burst();
    do_reset();
    q1_d.delete(); q1_l.delete(); q0_d.delete(); q0_l.delete();
    for (int i = 0; i < 10; i++) begin q1_d.push_back(8'hB0 + 8'(i)); q1_l.push_back(1'b0); end
    for (int i = 0; i < 6; i++) begin q0_d.push_back(8'hC0 + 8'(i)); q0_l.push_back(i[0]); end
    run_streams(0, 200);
    model_order();
    tests++;
    if (out_q.size() != exp_q.size()) begin fails++; $display("FAIL burst_count: %0d bytes, required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin fails++; $display("FAIL burst_byte[%0d]: required %h", i, exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    q0_d = '{8'hD0, 8'hD1, 8'hD2, 8'hD3}; q0_l = '{1'b0, 1'b0, 1'b0, 1'b1};
    q1_d.delete(); q1_l.delete();
    rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run_streams(2, 100);
    model_order();
    tests++;
    if (stalls != 2) begin fails++; $display("FAIL stall_cycles: %0d, required 2", stalls); end
    tests++;
    if (out_q.size() != exp_q.size()) begin fails++; $display("FAIL stall_count: %0d bytes, required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin fails++; $display("FAIL stall_byte[%0d]: required %h", i, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    s0_valid = 1'b1; s0_data = 8'hE0; s0_last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    s0_data = 8'hE1;
    reset_n = 1'b0;
    s1_valid = 1'b1; s1_data = 8'hF0; s1_last = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tests++;
    if (in_valid !== 1'b0 || grant !== 2'b00) begin
      fails++; $display("FAIL rst_mid: valid=%b grant=%b, required 0/00", in_valid, grant);
    end
    @(posedge clk); #1;
    tests++;
    if (grant !== 2'b01) begin fails++; $display("FAIL rst_tie: grant=%b, required 01", grant); end
    s0_valid = 1'b0; s1_valid = 1'b0;
  endtask

  task automatic test_random();
    int np, len;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
      np = $urandom_range(3, 6);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 7);
        for (int k = 0; k < len; k++) begin q0_d.push_back(8'($urandom)); q0_l.push_back(k == len - 1); end
      end
      np = $urandom_range(3, 6);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 7);
        for (int k = 0; k < len; k++) begin q1_d.push_back(8'($urandom)); q1_l.push_back(k == len - 1); end
      end
      run_streams(1, 2000);
      model_order();
      tests++;
      if (out_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count[%0d]: %0d bytes, required %0d", r, out_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        tests++;
        if (i >= out_q.size() || out_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_byte[%0d][%0d]: required %h", r, i, exp_q[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [1:0] eg;
    do_reset();
    s0_valid = 1'b1; s0_data = 8'h55; s0_last = 1'b0;
    s1_valid = 1'b1; s1_data = 8'h66; s1_last = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (grant !== 2'b01 || s0_ready !== 1'b1) begin
      fails++; $display("FAIL to_first: grant=%b ready0=%b, required 01/1", grant, s0_ready);
    end
    @(posedge clk); #1;
    s0_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_TIMEOUT_EN
      eg = k < TO ? 2'b01 : (k == TO ? 2'b00 : 2'b10);
`else
      eg = 2'b01;
`endif
      @(negedge clk);
      tests++;
      if (grant !== eg) begin fails++; $display("FAIL to_grant[%0d]: grant=%b, required %b", k, grant, eg); end
    end
    s1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_tie();
    test_max_burst();
    test_stall();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
